// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants and the sequencer state type.
package aes_pkg;

  localparam int AES_KEY_W    = 128;
  localparam int AES_NR       = 10;
  localparam int AES_RK_IDX_W = 4;
  localparam logic [AES_RK_IDX_W-1:0] AES_LAST_IDX = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/keyExpantion.sv
// Single AES-128 key-expansion round: output_key <= next round key of input_key, registered.
// key_num selects the round constant (1..10).
module keyExpantion (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [3:0]   key_num,
  input  logic [127:0] input_key,
  output logic [127:0] output_key
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = b;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, sq);
      sq = gf_mul(sq, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0]  w3;
  logic [31:0]  temp;
  logic [31:0]  w0n, w1n, w2n, w3n;

  always_comb begin
    w3   = input_key[31:0];
    temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon(key_num), 24'h0};
    w0n  = input_key[127:96] ^ temp;
    w1n  = input_key[95:64]  ^ w0n;
    w2n  = input_key[63:32]  ^ w1n;
    w3n  = input_key[31:0]   ^ w2n;
  end

  always_ff @(posedge clk) begin
    if (reset)       output_key <= '0;
    else if (enable) output_key <= {w0n, w1n, w2n, w3n};
  end

endmodule

// File: rtl/key_schedule_ctrl_bank.sv
// Storage for round keys 0..10 with one write port and a registered read (old data on same-index collision).
// Built only when KEY_SCHED_STORE_EN is defined.
module key_schedule_ctrl_bank
  import aes_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [AES_RK_IDX_W-1:0] wr_idx,
  input  logic [AES_KEY_W-1:0]    wr_data,
  input  logic                    rd_en,
  input  logic [AES_RK_IDX_W-1:0] rd_addr,
  output logic                    rd_valid,
  output logic [AES_KEY_W-1:0]    rd_data
);

  logic [AES_KEY_W-1:0] bank [0:AES_NR];

  // Contents survive reset; keys_valid tells the consumer whether they are complete.
  always_ff @(posedge clk) begin
    if (we && !reset && (wr_idx <= AES_LAST_IDX)) bank[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= (rd_addr <= AES_LAST_IDX) ? bank[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule sequencer: drives keyExpantion for rounds 1..10 and streams keys 0..10.
// Optional readback bank enabled by defining KEY_SCHED_STORE_EN.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_W = AES_KEY_W,
  parameter int NR    = AES_NR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  output logic             rk_strobe,
  output logic [3:0]       rk_idx,
  output logic [KEY_W-1:0] rk_out,
  input  logic             rd_en,
  input  logic [3:0]       rd_addr,
  output logic             rd_valid,
  output logic [KEY_W-1:0] rd_data
);

  state_t           state, state_nxt;
  logic [3:0]       round;
  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] exp_in;
  logic [KEY_W-1:0] exp_out;
  logic             exp_en;
  logic [3:0]       exp_num;
  logic             done_q;
  logic             keys_valid_q;
  logic             accept;
  logic             last_round;

  assign accept     = (state == IDLE) && start;
  assign last_round = (round == 4'(NR));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    exp_en    = 1'b0;
    exp_num   = 4'd0;
    exp_in    = key_reg;
    case (state)
      IDLE:   if (start) state_nxt = EXPAND;
      EXPAND: begin
        exp_en  = 1'b1;
        exp_num = round;
        // Round 1 starts from the cipher key; later rounds chain the expander's own output.
        exp_in  = (round == 4'd1) ? key_reg : exp_out;
        if (last_round) state_nxt = DRAIN;
      end
      DRAIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      round        <= 4'd0;
      key_reg      <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      done_q <= (state == DRAIN);
      if (accept) begin
        key_reg      <= key_in;
        round        <= 4'd1;
        keys_valid_q <= 1'b0;
      end else if (state == EXPAND && !last_round) begin
        round <= round + 4'd1;
      end else if (state == DRAIN) begin
        round        <= 4'd0;
        keys_valid_q <= 1'b1;
      end
    end
  end

  keyExpantion u_expander (
    .clk        (clk),
    .reset      (reset),
    .enable     (exp_en),
    .key_num    (exp_num),
    .input_key  (exp_in),
    .output_key (exp_out)
  );

  // Stream is one cycle behind the expander request: idx 0 comes straight from key_reg.
  always_comb begin
    rk_strobe = (state == EXPAND) || (state == DRAIN);
    rk_idx    = 4'd0;
    rk_out    = '0;
    if (state == DRAIN) begin
      rk_idx = 4'(NR);
      rk_out = exp_out;
    end else if (state == EXPAND) begin
      rk_idx = round - 4'd1;
      rk_out = (round == 4'd1) ? key_reg : exp_out;
    end
  end

  assign ready      = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = done_q;
  assign keys_valid = keys_valid_q;

`ifdef KEY_SCHED_STORE_EN
  key_schedule_ctrl_bank u_bank (
    .clk      (clk),
    .reset    (reset),
    .we       (rk_strobe),
    .wr_idx   (rk_idx),
    .wr_data  (rk_out),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );
`else
  logic unused_rd;
  assign unused_rd = ^{rd_en, rd_addr};
  assign rd_valid  = 1'b0;
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: known-answer table, FIPS-197 word-array model, random keys, corner sequences.
module tb_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         reset, start, rd_en;
  logic [127:0] key_in;
  logic [3:0]   rd_addr;
  logic         ready, busy, done, keys_valid, rk_strobe, rd_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out, rd_data;

  always #5 clk = ~clk;

  key_schedule_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .ready(ready), .busy(busy), .done(done), .keys_valid(keys_valid),
    .rk_strobe(rk_strobe), .rk_idx(rk_idx), .rk_out(rk_out),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] mk [0:10];
  logic [127:0] got [0:10];

  typedef struct {
    string        name;
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [8];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int tb_mul(input int a, input int b);
    int r, x, y;
    r = 0; x = a; y = b;
    while (y != 0) begin
      if ((y & 1) != 0) r = r ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
      y = y >> 1;
    end
    return r;
  endfunction

  // S-box from a brute-force field inverse followed by the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      int inv, s;
      inv = 0;
      for (int b = 1; b < 256; b++) if (tb_mul(a, b) == 1) inv = b;
      s = inv;
      for (int k = 1; k <= 4; k++) s = s ^ (((inv << k) | (inv >> (8 - k))) & 'hff);
      s = s ^ 'h63;
      sb[a] = s[7:0];
    end
  endtask

  // FIPS-197 key expansion over 44 words.
  task automatic model_calc(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    int rc;
    rc = 1;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc[7:0], 24'h0};
        rc = tb_mul(rc, 2);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},      128'(ready),      128'(1));
    chk({tag, "_busy"},       128'(busy),       128'(0));
    chk({tag, "_done"},       128'(done),       128'(0));
    chk({tag, "_keys_valid"}, 128'(keys_valid), 128'(0));
    chk({tag, "_rk_strobe"},  128'(rk_strobe),  128'(0));
    chk({tag, "_rk_idx"},     128'(rk_idx),     128'(0));
    chk({tag, "_rk_out"},     rk_out,           128'(0));
    chk({tag, "_rd_valid"},   128'(rd_valid),   128'(0));
    chk({tag, "_rd_data"},    rd_data,          128'(0));
  endtask

  // One full expansion from IDLE; optional stray start with key2 during cycle inj.
  task automatic run_expand(input logic [127:0] key, input int inj, input logic [127:0] key2);
    int errs;
    errs = 0;
    if (ready !== 1'b1) errs++;
    start = 1'b1; key_in = key;
    tick();
    start = 1'b0; key_in = ~key;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 11) begin
        if (rk_strobe !== 1'b1 || rk_idx !== 4'(c - 1) || busy !== 1'b1 ||
            ready !== 1'b0 || done !== 1'b0 || keys_valid !== 1'b0) errs++;
        got[c-1] = rk_out;
      end else begin
        if (rk_strobe !== 1'b0 || done !== 1'b1 || keys_valid !== 1'b1 ||
            ready !== 1'b1 || busy !== 1'b0 || rk_out !== '0) errs++;
      end
      if (c == inj) begin start = 1'b1; key_in = key2; end
      else start = 1'b0;
      if (c < 12) tick();
    end
    chk("stream_timing", 128'(errs), 128'(0));
  endtask

  function automatic int stream_mismatches();
    int m;
    m = 0;
    for (int i = 0; i <= 10; i++) if (got[i] !== mk[i]) m++;
    return m;
  endfunction

  initial begin
    logic [127:0] k;
    int errs;

    reset = 1'b1; start = 1'b0; rd_en = 1'b0; rd_addr = 4'd0; key_in = '0;
    vecs[0] = '{"fips_idx0",  FIPS_KEY, 0,  FIPS_KEY};
    vecs[1] = '{"fips_idx1",  FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{"fips_idx2",  FIPS_KEY, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{"fips_idx10", FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{"zero_idx0",  128'h0,   0,  128'h0};
    vecs[5] = '{"zero_idx1",  128'h0,   1,  128'h62636363626363636263636362636363};
    vecs[6] = '{"zero_idx2",  128'h0,   2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    vecs[7] = '{"ones_idx1",  {128{1'b1}}, 1, 128'he8e9e9e917161616e8e9e9e917161616};
    build_sbox();

    repeat (3) tick();
    chk_reset_vals("rst_hold");
    reset = 1'b0;
    tick();
    chk_reset_vals("rst_rel");

    foreach (vecs[v]) begin
      run_expand(vecs[v].key, 0, '0);
      chk(vecs[v].name, got[vecs[v].idx], vecs[v].exp);
      tick();
      chk("kv_one_cycle", 128'(keys_valid), 128'(1));
    end

    // Stray start during EXPAND must leave the FIPS stream untouched.
    model_calc(FIPS_KEY);
    run_expand(FIPS_KEY, 4, 128'hdeadbeef0123456789abcdeffedcba98);
    chk("ignored_start", 128'(stream_mismatches()), 128'(0));
    tick();
    chk("no_queued_start", 128'(busy), 128'(0));

    for (int n = 0; n < 12; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_calc(k);
      run_expand(k, 0, '0);
      chk("random_stream", 128'(stream_mismatches()), 128'(0));
      tick();
    end

`ifdef KEY_SCHED_STORE_EN
    for (int a = 10; a >= 0; a--) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      tick();
      chk("rd_valid", 128'(rd_valid), 128'(1));
      chk("rd_data", rd_data, mk[a]);
    end
    rd_addr = 4'd15;
    tick();
    chk("rd_oob_valid", 128'(rd_valid), 128'(1));
    chk("rd_oob_data", rd_data, 128'(0));
    rd_en = 1'b0;
    tick();
    chk("rd_idle_valid", 128'(rd_valid), 128'(0));
`else
    errs = 0;
    for (int a = 0; a < 16; a++) begin
      rd_en = a[0]; rd_addr = 4'(a);
      tick();
      if (rd_valid !== 1'b0 || rd_data !== '0) errs++;
    end
    rd_en = 1'b0;
    chk("no_store_rd", 128'(errs), 128'(0));
`endif

    // Reset in cycle 5 of an expansion.
    start = 1'b1; key_in = FIPS_KEY;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    errs = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done !== 1'b0 || keys_valid !== 1'b0 || busy !== 1'b0) errs++;
    end
    chk("mid_rst_quiet", 128'(errs), 128'(0));
    k = 128'h000102030405060708090a0b0c0d0e0f;
    model_calc(k);
    run_expand(k, 0, '0);
    chk("after_rst_stream", 128'(stream_mismatches()), 128'(0));
    tick();

    // start held high: back-to-back runs, accept in each done cycle.
    k = {$urandom, $urandom, $urandom, $urandom};
    model_calc(k);
    start = 1'b1; key_in = k;
    tick();
    errs = 0;
    for (int c = 1; c <= 36; c++) begin
      if (c % 12 == 0) begin
        if (done !== 1'b1 || keys_valid !== 1'b1 || rk_strobe !== 1'b0 || ready !== 1'b1) errs++;
      end else begin
        if (done !== 1'b0 || keys_valid !== 1'b0 || rk_strobe !== 1'b1 ||
            rk_idx !== 4'((c % 12) - 1) || rk_out !== mk[(c % 12) - 1]) errs++;
      end
      tick();
    end
    chk("b2b_runs", 128'(errs), 128'(0));
    chk("b2b_reaccept", 128'(busy), 128'(1));
    start = 1'b0;
    repeat (13) tick();
    chk("b2b_idle", 128'(ready), 128'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
